// File: rtl/aud_recorder.sv
// Left-channel I2S capture from a WM8731 codec (codec is clock master).
// Each 16-bit left sample becomes one addressed SRAM write strobe.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | not recording; waits for start with init done
// S_WAIT_LR | waiting for LRCK fall (start of left half frame)
// S_SKIP    | discarding the I2S one-bit delay slot
// S_CAPTURE | shifting in DATA_W bits, MSB first
// S_WRITE   | one-cycle write strobe with the assembled sample
// S_PAUSED  | recording suspended, address and length kept
module aud_recorder #(
    parameter int                ADDR_W   = 20,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init_done,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              AUD_BCLK,
    input  logic              AUD_ADCLRCK,
    input  logic              AUD_ADCDAT,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_len,
    output logic              o_recording,
    output logic              o_full
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LR,
        S_SKIP,
        S_CAPTURE,
        S_WRITE,
        S_PAUSED
    } state_t;

    state_t            state_q, state_nxt;
    logic [2:0]        bclk_sh, lrck_sh;
    logic [1:0]        dat_sh;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic              bclk_rise, lrck_fall, dat_sync, at_max;

    // [0],[1] form the synchroniser, [2] is the edge-detect history; data
    // stops at [1] so it stays aligned with the synchronised clocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bclk_sh <= '0;
            lrck_sh <= '0;
            dat_sh  <= '0;
        end else begin
            bclk_sh <= {bclk_sh[1:0], AUD_BCLK};
            lrck_sh <= {lrck_sh[1:0], AUD_ADCLRCK};
            dat_sh  <= {dat_sh[0], AUD_ADCDAT};
        end
    end

    assign bclk_rise = bclk_sh[1] & ~bclk_sh[2];
    assign lrck_fall = ~lrck_sh[1] & lrck_sh[2];
    assign dat_sync  = dat_sh[1];
    assign at_max    = (o_addr == MAX_ADDR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop && !i_pause && i_init_done) state_nxt = S_WAIT_LR;
            end
            S_WAIT_LR: begin
                if (i_stop)         state_nxt = S_IDLE;
                else if (i_pause)   state_nxt = S_PAUSED;
                else if (lrck_fall) state_nxt = S_SKIP;
            end
            S_SKIP: begin
                if (i_stop)         state_nxt = S_IDLE;
                else if (i_pause)   state_nxt = S_PAUSED;
                else if (bclk_rise) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (i_stop)                               state_nxt = S_IDLE;
                else if (i_pause)                         state_nxt = S_PAUSED;
                else if (bclk_rise && bit_cnt == LAST_BIT) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // the write always completes; controls only pick the successor
                if (at_max || i_stop) state_nxt = S_IDLE;
                else if (i_pause)     state_nxt = S_PAUSED;
                else                  state_nxt = S_WAIT_LR;
            end
            S_PAUSED: begin
                if (i_stop)                   state_nxt = S_IDLE;
                else if (i_start && !i_pause) state_nxt = S_WAIT_LR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
            o_addr  <= '0;
            o_len   <= '0;
            o_full  <= 1'b0;
        end else begin
            if (state_q == S_CAPTURE && state_nxt != S_IDLE && state_nxt != S_PAUSED) begin
                if (bclk_rise) begin
                    shift_q <= {shift_q[DATA_W-2:0], dat_sync};
                    bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                end
            end else begin
                bit_cnt <= '0;
            end

            if (state_q == S_IDLE && state_nxt == S_WAIT_LR) begin
                o_addr <= '0;
                o_len  <= '0;
                o_full <= 1'b0;
            end

            if (state_q == S_WRITE) begin
                o_len <= o_addr + ADDR_W'(1);
                if (at_max) o_full <= 1'b1;
                else        o_addr <= o_addr + ADDR_W'(1);
            end
        end
    end

    assign o_data      = shift_q;
    assign o_wr        = (state_q == S_WRITE);
    assign o_recording = (state_q == S_WAIT_LR) || (state_q == S_SKIP) ||
                         (state_q == S_CAPTURE) || (state_q == S_WRITE);

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Capture stage directly downstream of the WM8731 I2C initialiser.
- Held idle until the initialiser's done pulse/level is seen; then, on user start, deserialises left-channel 16-bit I2S samples from the codec (codec is BCLK/LRCK master, I2S, 16-bit) and emits one write strobe per sample with an incrementing SRAM word address.
- Pause/stop controls and a full flag bound the recording.

Parameters:
- ADDR_W, 20, width of the sample address / length counters
- DATA_W, 16, sample width; bits captured per frame
- MAX_ADDR, 20'hFFFFF, last writable address; write to it ends recording

Ports:
- clk  input  1  system clock, must be at least 4x AUD_BCLK
- rst  input  1  asynchronous active-low reset
- i_init_done  input  1  I2C configuration complete (level)
- i_start  input  1  one-cycle pulse: begin/resume recording
- i_pause  input  1  one-cycle pulse: pause recording
- i_stop  input  1  one-cycle pulse: end recording
- AUD_BCLK  input  1  codec bit clock (asynchronous, sampled)
- AUD_ADCLRCK  input  1  codec ADC frame clock, low = left channel
- AUD_ADCDAT  input  1  codec serial ADC data, MSB first
- o_data  output  DATA_W  captured sample, valid while o_wr=1
- o_addr  output  ADDR_W  write address, valid while o_wr=1
- o_wr  output  1  one-cycle write strobe
- o_len  output  ADDR_W  number of samples written since last start-from-IDLE
- o_recording  output  1  high in WAIT_LR, SKIP, CAPTURE, WRITE
- o_full  output  1  high once the sample at MAX_ADDR is written; cleared on next start from IDLE

Behaviour:
- Async reset (rst=0): state IDLE; o_data=0, o_addr=0, o_wr=0, o_len=0, o_recording=0, o_full=0; synchroniser flops=0; bit counter=0.
- AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT each pass a 2-flop synchroniser, then one history flop. BCLK rise = sync=1 & hist=0. LRCK fall = sync=0 & hist=1. All three share the same delay, so they stay mutually aligned.
- State IDLE:
  - i_start with i_init_done=1 -> WAIT_LR; o_addr=0, o_len=0, o_full=0.
  - i_start with i_init_done=0 is ignored.
- State WAIT_LR: on LRCK fall -> SKIP.
- State SKIP: on first BCLK rise -> CAPTURE with bit counter=0. This is the I2S one-bit delay; that bit is discarded.
- State CAPTURE:
  - On each BCLK rise, shift register <= {shift[DATA_W-2:0], dat_sync}, counter+1.
  - On the rise that captures bit DATA_W-1 (16th bit) -> WRITE.
- State WRITE (exactly 1 cycle):
  - o_wr=1, o_data=assembled sample (first bit = MSB), o_addr=current address; o_len becomes address+1 at the clock edge ending the cycle.
  - If o_addr==MAX_ADDR: set o_full, go to IDLE, o_addr not incremented.
  - Else o_addr+1 -> WAIT_LR.
  - o_wr is a single pulse per sample, at most one per LRCK period. Latency: o_wr rises 1 clk after the 16th synchronised BCLK rise is detected.
- Right-channel half frame (LRCK high) is never captured.
- Pause:
  - i_pause in WAIT_LR/SKIP/CAPTURE -> PAUSED; the partial sample is dropped and the counter cleared.
  - i_pause in WRITE is deferred: the write completes, then the next state is PAUSED.
  - In PAUSED: o_recording=0; i_start -> WAIT_LR, keeping o_addr/o_len.
- Stop: i_stop in any non-IDLE state -> IDLE; o_addr/o_len hold their last values. In WRITE the write still completes first.
- Simultaneous pulses: i_stop > i_pause > i_start.
- i_init_done falling while recording has no effect.
- Reset mid-operation aborts immediately with no o_wr.

Test Plan:
- Reset, i_init_done=0, pulse i_start -> stays IDLE, o_recording=0. Then i_init_done=1, i_start -> o_recording=1 within 1 clk.
- BFM at BCLK = clk/8, left word 16'hA5C3 after the I2S 1-bit delay, right word 16'h1234 -> o_wr pulses once, o_data=16'hA5C3, o_addr=0. Next frame 16'h8001 -> o_data=16'h8001, o_addr=1, o_len=2.
- Pulse i_pause mid-CAPTURE (after 7 bits), wait 3 frames, i_start -> the partial word is never written; the next o_wr carries the next full frame's word at the next address, with no gap in o_addr.
- MAX_ADDR=3, record 4 frames -> o_wr at addresses 0..3, o_full=1, o_len=4, back to IDLE; a 5th frame produces no o_wr.
- i_stop and i_start asserted in the same cycle during CAPTURE -> IDLE, no o_wr; a later i_start resets o_addr=0, o_len=0.
- rst asserted low mid-CAPTURE, asynchronous to clk -> all outputs return to zero immediately; no o_wr after release until a fresh i_start.
